bounded_step_counter: RTL

- Parametrised successor to the basic up/down/load counter.
- Adds the following over the basic counter:
  - programmable step size
  - programmable lower and upper bounds
  - wrap or saturate overflow handling
  - one-shot mode with a DONE state
  - terminal-count pulse and sticky overflow flag
- Used as a general timebase, address generator or event counter; outputs are registered except at_limit and cfg_err.

---
 rtl/bounded_step_counter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bounded_step_counter.sv
// Bounded step counter: an up/down counter with a programmable step,
// inclusive lower/upper bounds, wrap or saturate handling at the bounds,
// an optional one-shot DONE state, a registered terminal-count pulse and a
// sticky overflow flag. at_limit and cfg_err are combinational; the other
// outputs are registered.
module bounded_step_counter #(
  parameter int BITS      = 8,
  parameter int STEP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 up,
  input  logic                 load,
  input  logic [BITS-1:0]      D,
  input  logic [STEP_BITS-1:0] step,
  input  logic [BITS-1:0]      limit_lo,
  input  logic [BITS-1:0]      limit_hi,
  input  logic                 mode_sat,
  input  logic                 one_shot,
  input  logic                 clear_flags,
  output logic [BITS-1:0]      Q,
  output logic                 tc,
  output logic                 ovf_sticky,
  output logic                 done,
  output logic                 at_limit,
  output logic                 cfg_err
);

  // Two extra bits hold both the carry above limit_hi and the sign when a
  // downward step passes below zero.
  localparam int EW = BITS + 2;

  typedef enum logic {ACTIVE = 1'b0, DONE = 1'b1} state_t;

  state_t               state;
  state_t               state_nxt;
  logic signed [EW-1:0] q_ext;
  logic signed [EW-1:0] step_ext;
  logic signed [EW-1:0] lo_ext;
  logic signed [EW-1:0] hi_ext;
  logic signed [EW-1:0] n_ext;
  logic                 count_en;
  logic                 bound_evt;
  logic [BITS-1:0]      q_nxt;

  // Zero-extend an unsigned bus into the signed working width.
  function automatic logic signed [EW-1:0] widen(input logic [BITS-1:0] v);
    return $signed({2'b00, v});
  endfunction

  // Value loaded on a bound event: one-shot and saturate stop on the
  // crossed bound, wrap jumps to the opposite bound.
  function automatic logic [BITS-1:0] bound_target(
    input logic            dir_up,
    input logic            sat,
    input logic            oneshot,
    input logic [BITS-1:0] lo,
    input logic [BITS-1:0] hi
  );
    logic stop_on_crossed;
    stop_on_crossed = sat | oneshot;
    if (dir_up) return stop_on_crossed ? hi : lo;
    else        return stop_on_crossed ? lo : hi;
  endfunction

  assign q_ext    = widen(Q);
  assign lo_ext   = widen(limit_lo);
  assign hi_ext   = widen(limit_hi);
  assign step_ext = $signed({{(EW-STEP_BITS){1'b0}}, step});

  assign cfg_err  = (limit_lo > limit_hi);
  assign at_limit = (up && (Q == limit_hi)) || (!up && (Q == limit_lo));

  // Candidate count value and bound-event detection; step 0 never moves Q
  // and never raises an event, even when Q sits on or beyond a bound.
  always_comb begin
    count_en  = (state == ACTIVE) && enable && !load && !cfg_err && (step != '0);
    n_ext     = up ? (q_ext + step_ext) : (q_ext - step_ext);
    bound_evt = count_en && (up ? (n_ext > hi_ext) : (n_ext < lo_ext));
  end

  // Next counter value: load beats count beats hold.
  always_comb begin
    q_nxt = Q;
    if (load)           q_nxt = D;
    else if (bound_evt) q_nxt = bound_target(up, mode_sat, one_shot, limit_lo, limit_hi);
    else if (count_en)  q_nxt = n_ext[BITS-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ACTIVE;
    else          state <= state_nxt;
  end

  // FSM next state: a one-shot bound event parks in DONE until a load.
  always_comb begin
    state_nxt = state;
    if (load)                       state_nxt = ACTIVE;
    else if (bound_evt && one_shot) state_nxt = DONE;
  end

  // FSM outputs.
  always_comb begin
    done = (state == DONE);
  end

  // Counter value, terminal-count pulse and sticky overflow flag; a new
  // event wins over clear_flags in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q          <= '0;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      Q  <= q_nxt;
      tc <= bound_evt;
      if (bound_evt)        ovf_sticky <= 1'b1;
      else if (clear_flags) ovf_sticky <= 1'b0;
    end
  end

endmodule
